// File: rtl/circuit_1_pkg.sv
// circuit_1_pkg: shared defaults and saturating-increment helper for circuit_1
package circuit_1_pkg;

    localparam int RUN_LEN_DEF = 3;
    localparam int CNT_W_DEF   = 8;

    // Next run count for a high sample: cnt+1, clamped at lim
    function automatic int unsigned sat_inc(input int unsigned cnt, input int unsigned lim);
        return (cnt >= lim) ? lim : cnt + 1;
    endfunction

endpackage

// File: rtl/circuit_1_edge_det.sv
// circuit_1_edge_det: registered edge pulse of i_a; CIRCUIT_1_BOTH_EDGES_EN selects both-edge pulses
module circuit_1_edge_det (
    input  logic i_clock,
    input  logic i_nreset,
    input  logic i_a,
    output logic o_c
);

    logic r_a_q;
    logic r_c;
    logic w_c_nxt;

`ifdef CIRCUIT_1_BOTH_EDGES_EN
    assign w_c_nxt = i_a ^ r_a_q;
`else
    assign w_c_nxt = i_a & ~r_a_q;
`endif

    // Track the previous sample and register the edge pulse; reset wins
    always_ff @(posedge i_clock) begin
        if (i_nreset) begin
            r_a_q <= 1'b0;
            r_c   <= 1'b0;
        end else begin
            r_a_q <= i_a;
            r_c   <= w_c_nxt;
        end
    end

    assign o_c = r_c;

endmodule

// File: rtl/circuit_1.sv
// circuit_1: debounce level b (RUN_LEN high samples) and edge pulse c of input a; option CIRCUIT_1_BOTH_EDGES_EN
module circuit_1
    import circuit_1_pkg::*;
#(
    parameter int RUN_LEN = RUN_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic clock,
    input  logic nReset,
    input  logic a,
    output logic b,
    output logic c
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_b;
    logic [CNT_W:0]   w_cnt_inc;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_b_nxt;

    // One extra bit keeps cnt+1 from wrapping when cnt is at its maximum
    assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_cnt_nxt = a ? CNT_W'(sat_inc(32'(r_cnt), RUN_LEN)) : '0;
    assign w_b_nxt   = a & (w_cnt_inc >= (CNT_W+1)'(RUN_LEN));

    // Saturating run counter and qualified level; reset wins
    always_ff @(posedge clock) begin
        if (nReset) begin
            r_cnt <= '0;
            r_b   <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_b   <= w_b_nxt;
        end
    end

    assign b = r_b;

    circuit_1_edge_det u_edge_det (
        .i_clock  (clock),
        .i_nreset (nReset),
        .i_a      (a),
        .o_c      (c)
    );

endmodule

// File: tb/tb_circuit_1.sv
// tb_circuit_1: randomized and directed checks of circuit_1 against a run-length reference model
module tb_circuit_1;

    localparam int RUN_LEN = 3;

    logic clock = 1'b0;
    logic nReset = 1'b1;
    logic a = 1'b0;
    logic b;
    logic c;

    int n_checks = 0;
    int n_errors = 0;
    int run = 0;
    logic prev = 1'b0;
    logic exp_b = 1'b0;
    logic exp_c = 1'b0;

    circuit_1 #(.RUN_LEN(RUN_LEN), .CNT_W(8)) dut (
        .clock  (clock),
        .nReset (nReset),
        .a      (a),
        .b      (b),
        .c      (c)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input logic ia, input logic ir, input string tag);
        @(negedge clock);
        a = ia;
        nReset = ir;
        @(posedge clock);
        if (ir) begin
            run = 0;
            prev = 1'b0;
            exp_b = 1'b0;
            exp_c = 1'b0;
        end else begin
`ifdef CIRCUIT_1_BOTH_EDGES_EN
            exp_c = ia ^ prev;
`else
            exp_c = ia & ~prev;
`endif
            run = ia ? run + 1 : 0;
            exp_b = (run >= RUN_LEN);
            prev = ia;
        end
        #1;
        check({tag, ".b"}, b, exp_b);
        check({tag, ".c"}, c, exp_c);
    endtask

    initial begin
        repeat (2) tick(1'b0, 1'b1, "rst_a0");
        repeat (2) tick(1'b1, 1'b1, "rst_a1");
        repeat (3) tick(1'b0, 1'b0, "rel_a0");
        repeat (6) tick(1'b1, 1'b0, "rise_hold");
        repeat (2) tick(1'b0, 1'b0, "drop");
        tick(1'b1, 1'b0, "glitch");
        repeat (4) tick(1'b0, 1'b0, "glitch_after");
        repeat (300) tick(1'b1, 1'b0, "long_run");
        repeat (2) tick(1'b0, 1'b0, "long_drop");
        repeat (5) tick(1'b1, 1'b0, "pre_mid_rst");
        repeat (2) tick(1'b1, 1'b1, "mid_rst");
        repeat (5) tick(1'b1, 1'b0, "post_mid_rst");
        repeat (6) tick(1'($urandom_range(0, 1)), 1'b1, "rst_toggle");
        tick(1'b0, 1'b0, "pat0");
        tick(1'b1, 1'b0, "pat1");
        tick(1'b1, 1'b0, "pat2");
        tick(1'b0, 1'b0, "pat3");
        tick(1'b0, 1'b0, "pat4");
        for (int i = 0; i < 3000; i++) begin
            logic ra;
            logic rr;
            ra = ($urandom_range(0, 99) < (i % 200 < 100 ? 80 : 40)) ? 1'b1 : 1'b0;
            rr = ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0;
            tick(ra, rr, "rand");
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
